adsr_envelope: RTL and testbench
================================

# adsr_envelope

Single-voice ADSR envelope generator. It is the receiving end of the note trigger lines: one instance per trigger bit. A rising trigger starts a note and a falling trigger releases it. The block produces a 16-bit amplitude envelope, stepped once per sample tick, which feeds the voice amplitude multiplier.

## Interface
- `ENV_W`, 16: envelope and sustain-level width, unsigned.
- `RATE_W`, 16: width of the attack, decay and release step sizes.
- `clk`  in  1: system clock, the same clock as the trigger source.
- `rst_n`  in  1: asynchronous, active-low reset.
- `tick`  in  1: one-cycle sample-rate strobe; the envelope moves only on tick cycles.
- `trigger`  in  1: note gate. Posedge = note on, negedge = note off.
- `attack_rate`  in  RATE_W: increment per tick in ATTACK.
- `decay_rate`  in  RATE_W: decrement per tick in DECAY.
- `sustain_level`  in  ENV_W: hold level in SUSTAIN.
- `release_rate`  in  RATE_W: decrement per tick in RELEASE.
- `envelope`  out  ENV_W: current level, registered.
- `env_strobe`  out  1: registered pulse in the cycle `envelope` takes a tick update.
- `state`  out  3: current state encoding.
- `active`  out  1: high when state != IDLE, registered.

## Operation
- **States:** IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4. Encodings 5-7 are illegal and go to IDLE on the next clk.
- **Gate sampling:** `trigger` is registered into `trig_q` every clk.
  - rise = trigger & ~trig_q
  - fall = ~trigger & trig_q
- **Edge transitions** are evaluated every clk, not only on tick:
  - rise, from any state → ATTACK. The envelope keeps its current value (retrigger with no click).
  - fall, from ATTACK, DECAY or SUSTAIN → RELEASE. A fall in IDLE or RELEASE is ignored.
- **Edge plus tick in the same cycle:** the edge wins. The state changes and the envelope is not stepped; `env_strobe` stays low.
- **Tick, no edge.** All arithmetic is unsigned and done one bit wider than ENV_W, so nothing wraps.
  - ATTACK: if env + attack_rate ≥ 2^ENV_W−1, set env = 2^ENV_W−1 and go to DECAY. Otherwise env += attack_rate.
  - DECAY: if env ≤ sustain_level + decay_rate, set env = sustain_level and go to SUSTAIN. Otherwise env −= decay_rate.
  - SUSTAIN: env = sustain_level, tracking live changes to the input. No state change.
  - RELEASE: if env ≤ release_rate, set env = 0 and go to IDLE. Otherwise env −= release_rate.
  - IDLE: env = 0.
- **Zero rate:** a rate of 0 freezes the level in that phase. It is not an error.
- **sustain_level above the current env on DECAY entry:** the first DECAY tick jumps to sustain_level, then SUSTAIN.
- **`env_strobe`:** high for exactly the cycle after each stepped tick, i.e. aligned with the new `envelope` value.

## Timing
- **Reset (async assert, sync release):**
  - envelope = 0, state = IDLE, active = 0, env_strobe = 0, trig_q = 0.
  - If `trigger` is high when reset releases, the rise is seen on the first clk and the block enters ATTACK.
- **Edge latency:** if `trigger` changes before clk edge N, `state` and `active` reflect it after edge N.
- **Level latency:** the first envelope step comes on the first tick strictly after edge N. `envelope` updates at that tick's clk edge.
- **Reset mid-note:** the envelope drops to 0 immediately. No release tail.
- **Tick spacing:** no minimum; back-to-back ticks step on every cycle.

## Structure
- **Shared package `synth_pkg`:** state encodings, ENV_MAX = 2^ENV_W−1, default ENV_W and RATE_W. The voice mixer and noteTrigger-side logic reuse these.
- **Sub-module `gate_edge_detect`:** holds the `trig_q` register and outputs rise and fall. It takes `clk`, `rst_n` and the gate.
- **Core block:** one FSM always block plus a saturating add/subtract datapath.

## Test plan
1. **Full note.** attack 0x4000, decay 0x1000, sustain 0xC000, release 0x4000; trigger high, tick every 4 clk.
   - envelope 0x4000, 0x8000, 0xC000, 0xFFFF (DECAY), then 0xEFFF, 0xDFFF, 0xCFFF, 0xC000 (SUSTAIN).
   - Drop trigger: 0x8000, 0x4000, 0x0000, then IDLE with active = 0.
2. **Release during ATTACK.** Trigger low at env 0x8000 → RELEASE on the next clk, then 0x4000, then 0 (IDLE).
3. **Retrigger during RELEASE.** Trigger high again at env 0x4000 → ATTACK, then 0x8000 on the next tick. No reset to 0.
4. **Edge coincident with tick.** A rise lands on a tick cycle → state = ATTACK, envelope unchanged, env_strobe = 0. The next tick gives attack_rate.
5. **Zero rate and live sustain.** decay_rate = 0 → envelope holds 0xFFFF indefinitely. Separately, change sustain_level from 0xC000 to 0x2000 while in SUSTAIN → envelope reads 0x2000 after the next tick.
6. **Async reset mid-DECAY.** Assert rst_n = 0 at env 0xDFFF → envelope = 0, state = IDLE immediately, without a clk edge. Release reset with trigger held high → ATTACK after the first clk.

Source files
------------

// File: rtl/synth_pkg.sv
// Shared voice-synth definitions: ADSR state encodings, default widths and full-scale level.
// Reused by the envelope, the voice mixer and the note-trigger logic.
package synth_pkg;

    localparam int ENV_W_DEF  = 16;
    localparam int RATE_W_DEF = 16;

    localparam logic [ENV_W_DEF-1:0] ENV_MAX = '1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ATTACK  = 3'd1,
        ST_DECAY   = 3'd2,
        ST_SUSTAIN = 3'd3,
        ST_RELEASE = 3'd4
    } adsr_state_e;

    // States in which the gate is held, i.e. a note-off moves to RELEASE.
    function automatic logic is_gated(input adsr_state_e s);
        return s inside {ST_ATTACK, ST_DECAY, ST_SUSTAIN};
    endfunction

endpackage

// File: rtl/gate_edge_detect.sv
// Registers the note gate once per clk and flags its rising and falling edges.
module gate_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic gate_i,
    output logic rise_o,
    output logic fall_o
);

    logic trig_q;

    // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trig_q <= 1'b0;
        end else begin
            trig_q <= gate_i;
        end
    end

    assign rise_o = gate_i & ~trig_q;
    assign fall_o = ~gate_i & trig_q;

endmodule

// File: rtl/adsr_envelope.sv
// Single-voice ADSR envelope: gate edges steer the FSM every clk, the level steps on sample ticks
// through a saturating add/subtract evaluated one bit wider than the envelope.
module adsr_envelope
    import synth_pkg::*;
#(
    parameter int ENV_W  = ENV_W_DEF,
    parameter int RATE_W = RATE_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tick,
    input  logic              trigger,
    input  logic [RATE_W-1:0] attack_rate,
    input  logic [RATE_W-1:0] decay_rate,
    input  logic [ENV_W-1:0]  sustain_level,
    input  logic [RATE_W-1:0] release_rate,
    output logic [ENV_W-1:0]  envelope,
    output logic              env_strobe,
    output logic [2:0]        state,
    output logic              active
);

    localparam int EXT_W = ((ENV_W > RATE_W) ? ENV_W : RATE_W) + 1;
    localparam logic [EXT_W-1:0] ENV_MAX_EXT = EXT_W'({ENV_W{1'b1}});

    logic rise;
    logic fall;

    gate_edge_detect u_gate (
        .clk    (clk),
        .rst_n  (rst_n),
        .gate_i (trigger),
        .rise_o (rise),
        .fall_o (fall)
    );

    adsr_state_e      state_q, state_d;
    logic [ENV_W-1:0] env_q, env_d;
    logic             strobe_q, strobe_d;
    logic             active_q, active_d;

    logic [EXT_W-1:0] env_x;
    logic [EXT_W-1:0] att_sum;
    logic [EXT_W-1:0] dec_floor;

    assign env_x     = EXT_W'(env_q);
    assign att_sum   = env_x + EXT_W'(attack_rate);
    assign dec_floor = EXT_W'(sustain_level) + EXT_W'(decay_rate);

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        env_d    = env_q;
        strobe_d = 1'b0;

        if (!(state_q inside {ST_IDLE, ST_ATTACK, ST_DECAY, ST_SUSTAIN, ST_RELEASE})) begin
            state_d = ST_IDLE;
            env_d   = '0;
        end else if (rise) begin
            // Retrigger keeps the current level so there is no click.
            state_d = ST_ATTACK;
        end else if (fall && is_gated(state_q)) begin
            state_d = ST_RELEASE;
        end else if (tick) begin
            strobe_d = 1'b1;
            case (state_q)
                ST_ATTACK: begin
                    if (att_sum >= ENV_MAX_EXT) begin
                        env_d   = '1;
                        state_d = ST_DECAY;
                    end else begin
                        env_d = ENV_W'(att_sum);
                    end
                end
                ST_DECAY: begin
                    // Also covers a sustain level above the current envelope: jump straight up to it.
                    if (env_x <= dec_floor) begin
                        env_d   = sustain_level;
                        state_d = ST_SUSTAIN;
                    end else begin
                        env_d = ENV_W'(env_x - EXT_W'(decay_rate));
                    end
                end
                ST_SUSTAIN: env_d = sustain_level;
                ST_RELEASE: begin
                    if (env_x <= EXT_W'(release_rate)) begin
                        env_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        env_d = ENV_W'(env_x - EXT_W'(release_rate));
                    end
                end
                default: env_d = '0;
            endcase
        end

        active_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            env_q    <= '0;
            strobe_q <= 1'b0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            env_q    <= env_d;
            strobe_q <= strobe_d;
            active_q <= active_d;
        end
    end

    assign envelope   = env_q;
    assign env_strobe = strobe_q;
    assign state      = state_q;
    assign active     = active_q;

endmodule

// File: tb/tb_adsr_envelope.sv
// Self-checking bench for adsr_envelope: spec-derived vector table, directed corner sequences,
// and a randomized run compared every clk against an integer-arithmetic reference model.
module tb_adsr_envelope;

    localparam int S_IDLE    = 0;
    localparam int S_ATTACK  = 1;
    localparam int S_DECAY   = 2;
    localparam int S_SUSTAIN = 3;
    localparam int S_RELEASE = 4;
    localparam int FULL      = 65535;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tick = 1'b0;
    logic        trigger = 1'b0;
    logic [15:0] attack_rate = '0;
    logic [15:0] decay_rate = '0;
    logic [15:0] sustain_level = '0;
    logic [15:0] release_rate = '0;
    logic [15:0] envelope;
    logic        env_strobe;
    logic [2:0]  state;
    logic        active;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    int m_state;
    int m_env;
    bit m_trig;
    bit m_strobe;

    typedef struct {
        logic trig;
        int   pre;
        int   exp_env;
        int   exp_state;
    } vec_t;

    vec_t tbl [11];

    always #5 clk = ~clk;

    adsr_envelope dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .tick          (tick),
        .trigger       (trigger),
        .attack_rate   (attack_rate),
        .decay_rate    (decay_rate),
        .sustain_level (sustain_level),
        .release_rate  (release_rate),
        .envelope      (envelope),
        .env_strobe    (env_strobe),
        .state         (state),
        .active        (active)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state  = S_IDLE;
        m_env    = 0;
        m_trig   = 1'b0;
        m_strobe = 1'b0;
    endtask

    // Advance the model by one clk using the inputs currently applied.
    task automatic model_clock();
        bit rise_e, fall_e;
        int a, d, s, r;
        a = int'(attack_rate);
        d = int'(decay_rate);
        s = int'(sustain_level);
        r = int'(release_rate);
        rise_e   = trigger && !m_trig;
        fall_e   = !trigger && m_trig;
        m_trig   = trigger;
        m_strobe = 1'b0;
        if (rise_e) begin
            m_state = S_ATTACK;
        end else if (fall_e && (m_state == S_ATTACK || m_state == S_DECAY || m_state == S_SUSTAIN)) begin
            m_state = S_RELEASE;
        end else if (tick) begin
            m_strobe = 1'b1;
            if (m_state == S_ATTACK) begin
                if (m_env + a >= FULL) begin m_env = FULL; m_state = S_DECAY; end
                else m_env = m_env + a;
            end else if (m_state == S_DECAY) begin
                if (m_env <= s + d) begin m_env = s; m_state = S_SUSTAIN; end
                else m_env = m_env - d;
            end else if (m_state == S_SUSTAIN) begin
                m_env = s;
            end else if (m_state == S_RELEASE) begin
                if (m_env <= r) begin m_env = 0; m_state = S_IDLE; end
                else m_env = m_env - r;
            end else begin
                m_env = 0;
            end
        end
    endtask

    task automatic check_model();
        check("model_env", 32'(envelope), 32'(m_env));
        check("model_state", 32'(state), 32'(m_state));
        check("model_active", 32'(active), 32'(m_state != S_IDLE));
        check("model_strobe", 32'(env_strobe), 32'(m_strobe));
    endtask

    task automatic step();
        model_clock();
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic tick_step();
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        trigger = 1'b0;
        tick    = 1'b0;
        #2;
        model_reset();
        check_model();
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic set_rates(input logic [15:0] a, input logic [15:0] d,
                             input logic [15:0] s, input logic [15:0] r);
        attack_rate   = a;
        decay_rate    = d;
        sustain_level = s;
        release_rate  = r;
    endtask

    function automatic logic [15:0] rnd_rate();
        case ($urandom_range(0, 3))
            0:       return 16'h0000;
            1:       return 16'($urandom_range(1, 255));
            2:       return 16'($urandom_range(256, 16'h2000));
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        // Full note, tick every 4 clk: trigger level, idle clks before the tick, expected result.
        tbl[0]  = '{1'b1, 3, 'h4000, S_ATTACK};
        tbl[1]  = '{1'b1, 3, 'h8000, S_ATTACK};
        tbl[2]  = '{1'b1, 3, 'hC000, S_ATTACK};
        tbl[3]  = '{1'b1, 3, 'hFFFF, S_DECAY};
        tbl[4]  = '{1'b1, 3, 'hEFFF, S_DECAY};
        tbl[5]  = '{1'b1, 3, 'hDFFF, S_DECAY};
        tbl[6]  = '{1'b1, 3, 'hCFFF, S_DECAY};
        tbl[7]  = '{1'b1, 3, 'hC000, S_SUSTAIN};
        tbl[8]  = '{1'b0, 3, 'h8000, S_RELEASE};
        tbl[9]  = '{1'b0, 3, 'h4000, S_RELEASE};
        tbl[10] = '{1'b0, 3, 'h0000, S_IDLE};

        // Full note
        do_reset();
        set_rates(16'h4000, 16'h1000, 16'hC000, 16'h4000);
        for (int i = 0; i < 11; i++) begin
            trigger = tbl[i].trig;
            repeat (tbl[i].pre) step();
            tick_step();
            check($sformatf("tbl%0d_env", i), 32'(envelope), 32'(tbl[i].exp_env));
            check($sformatf("tbl%0d_state", i), 32'(state), 32'(tbl[i].exp_state));
            check($sformatf("tbl%0d_active", i), 32'(active), 32'(tbl[i].exp_state != S_IDLE));
        end

        // Release during ATTACK
        do_reset();
        trigger = 1'b1;
        step();
        tick_step();
        tick_step();
        check("relatk_env", 32'(envelope), 32'h8000);
        trigger = 1'b0;
        step();
        check("relatk_state", 32'(state), S_RELEASE);
        check("relatk_hold", 32'(envelope), 32'h8000);
        tick_step();
        check("relatk_env1", 32'(envelope), 32'h4000);
        tick_step();
        check("relatk_env0", 32'(envelope), 32'h0000);
        check("relatk_idle", 32'(state), S_IDLE);
        check("relatk_active", 32'(active), 32'h0);

        // Retrigger during RELEASE
        do_reset();
        trigger = 1'b1;
        step();
        tick_step();
        tick_step();
        trigger = 1'b0;
        step();
        tick_step();
        check("retrig_rel_env", 32'(envelope), 32'h4000);
        trigger = 1'b1;
        step();
        check("retrig_state", 32'(state), S_ATTACK);
        check("retrig_keep", 32'(envelope), 32'h4000);
        tick_step();
        check("retrig_env", 32'(envelope), 32'h8000);

        // Edge coincident with tick
        do_reset();
        trigger = 1'b1;
        tick    = 1'b1;
        step();
        tick    = 1'b0;
        check("coinc_state", 32'(state), S_ATTACK);
        check("coinc_env", 32'(envelope), 32'h0000);
        check("coinc_strobe", 32'(env_strobe), 32'h0);
        tick_step();
        check("coinc_next_env", 32'(envelope), 32'h4000);
        check("coinc_next_strobe", 32'(env_strobe), 32'h1);
        step();
        check("coinc_strobe_drop", 32'(env_strobe), 32'h0);

        // Zero decay rate, then live sustain change
        do_reset();
        set_rates(16'h4000, 16'h0000, 16'hC000, 16'h4000);
        trigger = 1'b1;
        step();
        repeat (4) tick_step();
        repeat (20) tick_step();
        check("zero_dec_env", 32'(envelope), 32'hFFFF);
        check("zero_dec_state", 32'(state), S_DECAY);
        decay_rate = 16'h1000;
        repeat (4) tick_step();
        check("sus_env", 32'(envelope), 32'hC000);
        check("sus_state", 32'(state), S_SUSTAIN);
        sustain_level = 16'h2000;
        step();
        check("sus_wait_tick", 32'(envelope), 32'hC000);
        tick_step();
        check("sus_live", 32'(envelope), 32'h2000);

        // Async reset mid-DECAY, released with trigger held high
        do_reset();
        set_rates(16'h4000, 16'h1000, 16'hC000, 16'h4000);
        trigger = 1'b1;
        step();
        repeat (6) tick_step();
        check("arst_pre_env", 32'(envelope), 32'hDFFF);
        check("arst_pre_state", 32'(state), S_DECAY);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("arst_env", 32'(envelope), 32'h0000);
        check("arst_state", 32'(state), S_IDLE);
        check("arst_active", 32'(active), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("arst_rel_state", 32'(state), S_ATTACK);
        check("arst_rel_active", 32'(active), 32'h1);

        // Randomized run against the reference model
        do_reset();
        set_rates(rnd_rate(), rnd_rate(), 16'($urandom), rnd_rate());
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) do_reset();
            if (c % 250 == 0)
                set_rates(rnd_rate(), rnd_rate(), 16'($urandom), rnd_rate());
            if ($urandom_range(0, 99) == 0) sustain_level = 16'($urandom);
            if ($urandom_range(0, 19) == 0) trigger = ~trigger;
            tick = ($urandom_range(0, 2) == 0);
            step();
        end
        tick = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
